// File: rtl/equiv_time_capture.sv
// Equivalent-time capture: writes each ADC sample into a frame buffer at its delay phase,
// then freezes the reconstructed frame for readout.
module equiv_time_capture #(
   parameter int DATA_W     = 10,
   parameter int NUM_PHASES = 100,
   parameter int ADDR_W     = 7
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              samp_strobe,
   input  logic              sweep_sync,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              frame_ready,
   output logic              busy,
   output logic              sync_err,
   output logic [ADDR_W-1:0] wr_phase,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SYNC = 2'd1,
      CAPTURE   = 2'd2,
      READY     = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_PHASE = ADDR_W'(NUM_PHASES - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_phase_q, wr_phase_d;
   logic                sync_err_q, sync_err_d;
   logic                frame_ready_q, frame_ready_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;

   logic [DATA_W-1:0]   mem [NUM_PHASES];

   always_comb begin
      state_d    = state_q;
      wr_phase_d = wr_phase_q;
      sync_err_d = sync_err_q;
      wr_en      = 1'b0;
      wr_addr    = '0;

      // arm outranks any strobe in the same cycle, in every state
      if (arm) begin
         state_d    = WAIT_SYNC;
         wr_phase_d = '0;
         sync_err_d = 1'b0;
      end else begin
         case (state_q)
            WAIT_SYNC: begin
               if (samp_strobe && sweep_sync) begin
                  wr_en      = 1'b1;
                  wr_addr    = '0;
                  wr_phase_d = ADDR_W'(1);
                  state_d    = CAPTURE;
               end
            end
            CAPTURE: begin
               if (samp_strobe && sweep_sync) begin
                  // Out-of-sequence sync restarts the frame at phase 0
                  sync_err_d = 1'b1;
                  wr_en      = 1'b1;
                  wr_addr    = '0;
                  wr_phase_d = ADDR_W'(1);
               end else if (samp_strobe) begin
                  wr_en   = 1'b1;
                  wr_addr = wr_phase_q;
                  if (wr_phase_q == LAST_PHASE) begin
                     wr_phase_d = '0;
                     state_d    = READY;
                  end else begin
                     wr_phase_d = wr_phase_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d        = (state_d == WAIT_SYNC) || (state_d == CAPTURE);
      frame_ready_d = (state_d == READY);
      rd_data_d     = (rd_addr <= LAST_PHASE) ? mem[rd_addr] : '0;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         wr_phase_q    <= '0;
         sync_err_q    <= 1'b0;
         frame_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         wr_phase_q    <= wr_phase_d;
         sync_err_q    <= sync_err_d;
         frame_ready_q <= frame_ready_d;
         busy_q        <= busy_d;
         rd_data_q     <= rd_data_d;
      end
   end

   // Buffer contents survive reset; read samples the pre-write value
   always_ff @(posedge sys_clk) begin
      if (wr_en && (wr_addr <= LAST_PHASE)) begin
         mem[wr_addr] <= adc_data;
      end
   end

   assign rd_data     = rd_data_q;
   assign frame_ready = frame_ready_q;
   assign busy        = busy_q;
   assign sync_err    = sync_err_q;
   assign wr_phase    = wr_phase_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_equiv_time_capture.sv
// Directed bench for equiv_time_capture: status checks inline, buffer readout checked by
// a queue-based scoreboard that compares rd_data one cycle after each read request.
module tb_equiv_time_capture;

   logic       clk;
   logic       rst;
   logic       arm;
   logic       samp_strobe;
   logic       sweep_sync;
   logic [9:0] adc_data;
   logic [6:0] rd_addr;
   logic [9:0] rd_data;
   logic       frame_ready;
   logic       busy;
   logic       sync_err;
   logic [6:0] wr_phase;
   logic [1:0] state_dbg;

   logic       rd_req;
   logic       rd_vld;
   logic [9:0] exp_q[$];
   logic [9:0] exp_mem [128];

   int checks = 0;
   int errors = 0;

   equiv_time_capture dut (
      .sys_clk     (clk),
      .rst         (rst),
      .arm         (arm),
      .samp_strobe (samp_strobe),
      .sweep_sync  (sweep_sync),
      .adc_data    (adc_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_ready (frame_ready),
      .busy        (busy),
      .sync_err    (sync_err),
      .wr_phase    (wr_phase),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // read-valid pipeline: rd_data is due one clock after a request
   always @(posedge clk or posedge rst) begin
      if (rst) rd_vld <= 1'b0;
      else     rd_vld <= rd_req;
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (rd_vld) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_data_unexpected: got %0h with no expected value queued", rd_data);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic strobe(input logic s, input logic [9:0] d);
      samp_strobe = 1'b1;
      sweep_sync  = s;
      adc_data    = d;
      tick();
      samp_strobe = 1'b0;
      sweep_sync  = 1'b0;
   endtask

   task automatic rd(input logic [6:0] a, input logic [9:0] e);
      rd_addr = a;
      rd_req  = 1'b1;
      exp_q.push_back(e);
      tick();
      rd_req  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; samp_strobe = 1'b0; sweep_sync = 1'b0;
      adc_data = '0; rd_addr = '0; rd_req = 1'b0;
      repeat (3) tick();
      chk("reset_busy", busy, 0);
      chk("reset_frame_ready", frame_ready, 0);
      chk("reset_sync_err", sync_err, 0);
      chk("reset_wr_phase", wr_phase, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_state", state_dbg, 0);
      rst = 1'b0;
      tick();

      // 1: full sweep, data 3k at phase k
      strobe(1'b1, 10'h0AA);
      chk("idle_strobe_ignored", busy, 0);
      do_arm();
      chk("t1_busy_after_arm", busy, 1);
      chk("t1_wr_phase_after_arm", wr_phase, 0);
      for (int k = 0; k < 100; k++) begin
         strobe(k == 0, 10'(3 * k));
         exp_mem[k] = 10'(3 * k);
         if (k == 0)  chk("t1_wr_phase_after_first", wr_phase, 1);
         if (k == 98) chk("t1_not_ready_at_99", frame_ready, 0);
      end
      chk("t1_frame_ready", frame_ready, 1);
      chk("t1_busy_low", busy, 0);
      chk("t1_sync_err", sync_err, 0);
      chk("t1_wr_phase_wrap", wr_phase, 0);
      for (int k = 0; k < 100; k++) rd(7'(k), exp_mem[k]);

      // 4: strobes in READY leave the frame frozen
      for (int k = 0; k < 10; k++) strobe(k == 0, 10'h155);
      chk("t4_frame_ready_held", frame_ready, 1);
      rd(7'd0, exp_mem[0]);
      rd(7'd5, exp_mem[5]);
      rd(7'd99, exp_mem[99]);
      do_arm();
      chk("t4_frame_ready_cleared", frame_ready, 0);
      chk("t4_busy_set", busy, 1);

      // 2: non-sync strobes wait, then sync opens the frame
      for (int k = 0; k < 5; k++) begin
         strobe(1'b0, 10'h3FF);
         chk("t2_wait_wr_phase", wr_phase, 0);
         chk("t2_wait_busy", busy, 1);
      end
      strobe(1'b1, 10'h012);
      exp_mem[0] = 10'h012;
      chk("t2_wr_phase_after_sync", wr_phase, 1);
      chk("t2_busy", busy, 1);
      rd(7'd0, exp_mem[0]);
      rd(7'd1, exp_mem[1]);

      // 3: out-of-sequence sync at phase 40
      for (int k = 1; k < 40; k++) begin
         strobe(1'b0, 10'(10'h100 + k));
         exp_mem[k] = 10'(10'h100 + k);
      end
      chk("t3_wr_phase_40", wr_phase, 40);
      strobe(1'b1, 10'h2AA);
      exp_mem[0] = 10'h2AA;
      chk("t3_sync_err_set", sync_err, 1);
      chk("t3_wr_phase_restart", wr_phase, 1);
      for (int k = 1; k < 100; k++) begin
         strobe(1'b0, 10'(10'h200 + k));
         exp_mem[k] = 10'(10'h200 + k);
         if (k == 98) chk("t3_not_ready_early", frame_ready, 0);
      end
      chk("t3_frame_ready", frame_ready, 1);
      chk("t3_sync_err_sticky", sync_err, 1);
      rd(7'd0, exp_mem[0]);
      rd(7'd1, exp_mem[1]);
      rd(7'd50, exp_mem[50]);
      rd(7'd99, exp_mem[99]);
      do_arm();
      chk("t3_sync_err_cleared", sync_err, 0);

      // 5: asynchronous reset mid-capture at phase 50
      strobe(1'b1, 10'h001);
      exp_mem[0] = 10'h001;
      for (int k = 1; k < 50; k++) begin
         strobe(1'b0, 10'(10'h050 + k));
         exp_mem[k] = 10'(10'h050 + k);
      end
      chk("t5_wr_phase_50", wr_phase, 50);
      rd_addr = 7'd0;
      tick();
      chk("t5_rd_data_before_rst", rd_data, 10'h001);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_busy", busy, 0);
      chk("t5_async_frame_ready", frame_ready, 0);
      chk("t5_async_sync_err", sync_err, 0);
      chk("t5_async_rd_data", rd_data, 0);
      chk("t5_async_wr_phase", wr_phase, 0);
      tick();
      rst = 1'b0;
      tick();
      strobe(1'b1, 10'h3C3);
      strobe(1'b0, 10'h3C3);
      chk("t5_post_rst_busy", busy, 0);
      chk("t5_post_rst_wr_phase", wr_phase, 0);
      rd(7'd0, exp_mem[0]);
      rd(7'd1, exp_mem[1]);

      // 6: arm+strobe collision, out-of-range read, read-during-write
      do_arm();
      arm = 1'b1;
      strobe(1'b1, 10'h0AB);
      arm = 1'b0;
      chk("t6_collision_wr_phase", wr_phase, 0);
      chk("t6_collision_busy", busy, 1);
      rd(7'd0, exp_mem[0]);
      rd(7'd100, 10'h000);
      rd(7'd127, 10'h000);
      strobe(1'b1, 10'h011);
      exp_mem[0] = 10'h011;
      for (int k = 1; k < 7; k++) begin
         strobe(1'b0, 10'(10'h300 + k));
         exp_mem[k] = 10'(10'h300 + k);
      end
      chk("t6_wr_phase_7", wr_phase, 7);
      rd_addr = 7'd7;
      rd_req  = 1'b1;
      exp_q.push_back(exp_mem[7]);
      strobe(1'b0, 10'h3E7);
      rd_req  = 1'b0;
      exp_mem[7] = 10'h3E7;
      rd(7'd7, exp_mem[7]);
      rd(7'd0, exp_mem[0]);

      repeat (3) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
